// File: rtl/alert_handler_class_esc.sv
// Alert class escalation: trigger accumulator, interrupt timeout and a
// four-phase escalation sequencer with a lockable clear.
module alert_handler_class_esc #(
   parameter int AccuCntDw = 16,
   parameter int EscCntDw  = 32,
   parameter int N_ESC_SEV = 4,
   parameter int N_PHASES  = 4,
   parameter int PHASE_DW  = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic                         class_trig_i,
   input  logic                         clr_i,
   input  logic                         lock_en_i,
   input  logic [AccuCntDw-1:0]         accu_thresh_i,
   input  logic [EscCntDw-1:0]          timeout_cyc_i,
   input  logic [N_PHASES*EscCntDw-1:0] phase_cyc_i,
   input  logic [N_ESC_SEV-1:0]         esc_en_i,
   input  logic [N_ESC_SEV*PHASE_DW-1:0] esc_map_i,
   output logic [AccuCntDw-1:0]         accu_cnt_o,
   output logic                         accu_trig_o,
   output logic [EscCntDw-1:0]          esc_cnt_o,
   output logic [2:0]                   state_o,
   output logic [N_ESC_SEV-1:0]         esc_sig_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      TIMEOUT  = 3'b001,
      TERMINAL = 3'b011,
      PHASE0   = 3'b100,
      PHASE1   = 3'b101,
      PHASE2   = 3'b110,
      PHASE3   = 3'b111
   } state_e;

   state_e               state_q, state_d;
   logic [AccuCntDw-1:0] accu_q, accu_d;
   logic [EscCntDw-1:0]  esc_q, esc_d, esc_inc, phase_cyc;
   logic                 lock_q, lock_d;
   logic                 trig, clr_eff, phase_done, timeout_done;

   assign trig         = en_i & class_trig_i;
   assign clr_eff      = clr_i & ~lock_q;
   assign accu_trig_o  = trig & (accu_q >= accu_thresh_i);
   assign esc_inc      = (&esc_q) ? esc_q : esc_q + EscCntDw'(1);
   assign phase_cyc    = phase_cyc_i[state_q[1:0]*EscCntDw +: EscCntDw];
   assign phase_done   = (phase_cyc == '0) ||
                         (esc_q >= phase_cyc - EscCntDw'(1));
   assign timeout_done = esc_q >= timeout_cyc_i - EscCntDw'(1);

   always_comb begin
      accu_d = accu_q;
      if (clr_eff) begin
         accu_d = '0;
      end else if (trig && !(&accu_q)) begin
         accu_d = accu_q + AccuCntDw'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      esc_d   = esc_q;
      lock_d  = lock_q;
      unique case (state_q)
         IDLE: begin
            if (accu_trig_o) begin
               state_d = PHASE0;
               esc_d   = '0;
            end else if (trig && timeout_cyc_i != '0) begin
               state_d = TIMEOUT;
               esc_d   = '0;
            end
         end
         TIMEOUT: begin
            esc_d = esc_inc;
            if (accu_trig_o || timeout_done) begin
               state_d = PHASE0;
               esc_d   = '0;
            end
         end
         PHASE0, PHASE1, PHASE2: begin
            esc_d = esc_inc;
            if (phase_done) begin
               state_d = state_e'(state_q + 3'd1);
               esc_d   = '0;
            end
         end
         PHASE3: begin
            esc_d = esc_inc;
            if (phase_done) begin
               state_d = TERMINAL;
               esc_d   = '0;
            end
         end
         TERMINAL: begin
            esc_d = esc_q;
         end
         default: begin
            state_d = IDLE;
            esc_d   = '0;
         end
      endcase
      // an unlocked clear overrides any escalation progress this cycle
      if (clr_eff) begin
         state_d = IDLE;
         esc_d   = '0;
      end
      if (lock_en_i && state_d == PHASE0 && state_q != PHASE0) begin
         lock_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         accu_q  <= '0;
         esc_q   <= '0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         accu_q  <= accu_d;
         esc_q   <= esc_d;
         lock_q  <= lock_d;
      end
   end

   always_comb begin
      esc_sig_o = '0;
      for (int e = 0; e < N_ESC_SEV; e++) begin
         esc_sig_o[e] = esc_en_i[e] & state_q[2] &
            (PHASE_DW'(state_q[1:0]) >= esc_map_i[e*PHASE_DW +: PHASE_DW]);
      end
   end

   assign accu_cnt_o = accu_q;
   assign esc_cnt_o  = esc_q;
   assign state_o    = state_q;

endmodule
